// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: EX-stage bundle between the pipeline and the HI/LO
// multiply/divide unit.
//   master (pipeline side) drives: flush, in_valid, funct, operand_1, operand_2
//                          reads:  stall_req, result, hi, lo
//   slave  (ex_muldiv_unit) sees the reverse directions.
interface ex_muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  flush;
  logic                  in_valid;
  logic [5:0]            funct;
  logic [DATA_WIDTH-1:0] operand_1;
  logic [DATA_WIDTH-1:0] operand_2;
  logic                  stall_req;
  logic [DATA_WIDTH-1:0] result;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output flush, in_valid, funct, operand_1, operand_2,
    input  stall_req, result, hi, lo
  );

  modport slave (
    input  flush, in_valid, funct, operand_1, operand_2,
    output stall_req, result, hi, lo
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: EX-stage HI/LO class executor. Multi-cycle MULT/MULTU,
// radix-2 restoring DIV/DIVU (one quotient bit per cycle), MTHI/MTLO/MFHI/MFLO,
// and the HI/LO architectural registers.
// Ports:
//   clk    - clock
//   rst_n  - synchronous active-low reset
//   bus    - ex_muldiv_unit_if.slave: flush, in_valid, funct, operand_1,
//            operand_2 in; stall_req, result (combinational), hi, lo out
//
// state | meaning
// IDLE  | waiting; accepts MULT*/DIV*, serves MT*/MF*
// MUL   | multiply in flight, counting MUL_CYCLES down
// DIV   | divide in flight, one quotient bit per cycle
// DONE  | hi/lo just written; pipeline advances once, no restart
module ex_muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  ex_muldiv_unit_if.slave bus
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2((W > MUL_CYCLES) ? W : MUL_CYCLES) + 1;

  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MTHI = 6'h11;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_MTLO = 6'h13;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     hi_q, lo_q;
  logic [W-1:0]     op_a;      // multiplicand, or dividend/quotient shift register
  logic [W-1:0]     op_b;      // multiplier, or divisor magnitude
  logic [W-1:0]     rem;
  logic             mul_signed, neg_q, neg_r;

  logic is_mul, is_div, is_signed, start;
  logic op1_neg, op2_neg;
  logic [W-1:0]   abs_1, abs_2;
  logic [2*W-1:0] ext_a, ext_b, prod;
  logic [W:0]     rem_sh, diff;
  logic [W-1:0]   q_next, r_next;

  // 18h/19h are MULT/MULTU, 1Ah/1Bh DIV/DIVU; bit 0 clear means signed.
  assign is_mul    = (bus.funct[5:1] == 5'b01100);
  assign is_div    = (bus.funct[5:1] == 5'b01101);
  assign is_signed = ~bus.funct[0];
  assign start     = bus.in_valid & (state == IDLE) & (is_mul | is_div) & ~bus.flush;

  assign op1_neg = is_signed & bus.operand_1[W-1];
  assign op2_neg = is_signed & bus.operand_2[W-1];
  assign abs_1   = op1_neg ? (~bus.operand_1 + 1'b1) : bus.operand_1;
  assign abs_2   = op2_neg ? (~bus.operand_2 + 1'b1) : bus.operand_2;

  // Low half of a 2W x 2W product of extended operands equals the exact
  // signed (or unsigned) W x W product.
  assign ext_a = mul_signed ? {{W{op_a[W-1]}}, op_a} : {{W{1'b0}}, op_a};
  assign ext_b = mul_signed ? {{W{op_b[W-1]}}, op_b} : {{W{1'b0}}, op_b};
  assign prod  = ext_a * ext_b;

  // Restoring step: the dividend MSB shifts out of op_a into the remainder,
  // and the quotient bit shifts into op_a from the bottom.
  assign rem_sh = {rem, op_a[W-1]};
  assign diff   = rem_sh - {1'b0, op_b};
  assign q_next = {op_a[W-2:0], ~diff[W]};
  assign r_next = diff[W] ? rem_sh[W-1:0] : diff[W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      op_a       <= '0;
      op_b       <= '0;
      rem        <= '0;
      mul_signed <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
    end else if (bus.flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && is_mul) begin
            op_a       <= bus.operand_1;
            op_b       <= bus.operand_2;
            mul_signed <= is_signed;
            cnt        <= CNT_W'(MUL_CYCLES - 1);
            state      <= MUL;
          end else if (start && bus.operand_2 == '0) begin
            lo_q  <= '1;
            hi_q  <= bus.operand_1;
            state <= DONE;
          end else if (start) begin
            op_a  <= abs_1;
            op_b  <= abs_2;
            rem   <= '0;
            neg_q <= op1_neg ^ op2_neg;
            neg_r <= op1_neg;
            cnt   <= CNT_W'(W - 1);
            state <= DIV;
          end else if (bus.in_valid && bus.funct == F_MTHI) begin
            hi_q <= bus.operand_1;
          end else if (bus.in_valid && bus.funct == F_MTLO) begin
            lo_q <= bus.operand_1;
          end
        end
        MUL: begin
          if (cnt == '0) begin
            {hi_q, lo_q} <= prod;
            state        <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DIV: begin
          op_a <= q_next;
          rem  <= r_next;
          if (cnt == '0) begin
            lo_q  <= neg_q ? (~q_next + 1'b1) : q_next;
            hi_q  <= neg_r ? (~r_next + 1'b1) : r_next;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall_req = rst_n & ~bus.flush &
                         (start | (state == MUL) | (state == DIV));

  always_comb begin
    bus.result = '0;
    if (rst_n) begin
      if (bus.funct == F_MFHI)      bus.result = hi_q;
      else if (bus.funct == F_MFLO) bus.result = lo_q;
    end
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;
  localparam int W  = 32;
  localparam int MC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.DATA_WIDTH(W)) bus ();

  ex_muldiv_unit #(.DATA_WIDTH(W), .MUL_CYCLES(MC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    bus.funct     = v.funct;
    bus.operand_1 = v.a;
    bus.operand_2 = v.b;
    bus.in_valid  = 1'b1;
    #1;
    n = 0;
    while (bus.stall_req === 1'b1 && n < 100) begin
      n++;
      step();
    end
    chk({v.name, "_stall_cycles"}, n, v.stalls);
    chk({v.name, "_hi"}, bus.hi, v.hi);
    chk({v.name, "_lo"}, bus.lo, v.lo);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk({v.name, "_no_restart_stall"}, {31'b0, bus.stall_req}, 32'd0);
    chk({v.name, "_hi_held"}, bus.hi, v.hi);
  endtask

  initial begin
    vecs[0] = '{"mult_neg",     6'h18, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1 + MC};
    vecs[1] = '{"multu_max",    6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1 + MC};
    vecs[2] = '{"mult_minsq",   6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1 + MC};
    vecs[3] = '{"multu_carry",  6'h19, 32'h80000000, 32'h2,        32'h00000001, 32'h00000000, 1 + MC};
    vecs[4] = '{"div_neg7_2",   6'h1A, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[5] = '{"divu_100_7",   6'h1B, 32'd100,      32'd7,        32'd2,        32'd14,       33};
    vecs[6] = '{"divu_by_zero", 6'h1B, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1};
    vecs[7] = '{"div_overflow", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[8] = '{"div_7_neg2",   6'h1A, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
    vecs[9] = '{"div_neg7_neg2",6'h1A, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 33};

    bus.flush     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.funct     = 6'h18;
    bus.operand_1 = 32'd3;
    bus.operand_2 = 32'd4;
    #1;
    chk("reset_stall", {31'b0, bus.stall_req}, 32'd0);
    step();
    step();
    bus.funct = 6'h10;
    #1;
    chk("reset_result", bus.result, 32'd0);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i]);
    end

    // MTHI then MFHI, MTLO then MFLO
    bus.in_valid  = 1'b1;
    bus.funct     = 6'h11;
    bus.operand_1 = 32'h1234;
    #1;
    chk("mthi_no_stall", {31'b0, bus.stall_req}, 32'd0);
    chk("mthi_result_zero", bus.result, 32'd0);
    step();
    bus.funct = 6'h10;
    #1;
    chk("mfhi_result", bus.result, 32'h1234);
    chk("mfhi_no_stall", {31'b0, bus.stall_req}, 32'd0);
    bus.funct     = 6'h13;
    bus.operand_1 = 32'h5678;
    step();
    bus.funct = 6'h12;
    #1;
    chk("mflo_result", bus.result, 32'h5678);

    // flush suppresses an MT write
    bus.funct     = 6'h11;
    bus.operand_1 = 32'hDEAD;
    bus.flush     = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.funct = 6'h10;
    #1;
    chk("flush_mthi_blocked", bus.result, 32'h1234);

    // unknown funct
    bus.funct     = 6'h20;
    bus.operand_1 = 32'hCAFE;
    #1;
    chk("other_stall", {31'b0, bus.stall_req}, 32'd0);
    chk("other_result", bus.result, 32'd0);
    step();
    chk("other_hi", bus.hi, 32'h1234);

    // DIV flushed at iteration 10
    bus.funct     = 6'h1B;
    bus.operand_1 = 32'd100;
    bus.operand_2 = 32'd7;
    #1;
    chk("div_flush_start_stall", {31'b0, bus.stall_req}, 32'd1);
    for (int i = 0; i < 10; i++) step();
    chk("div_flush_busy_stall", {31'b0, bus.stall_req}, 32'd1);
    bus.flush = 1'b1;
    #1;
    chk("div_flush_stall_drop", {31'b0, bus.stall_req}, 32'd0);
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("div_flush_idle_stall", {31'b0, bus.stall_req}, 32'd0);
    for (int i = 0; i < 40; i++) step();
    chk("div_flush_hi", bus.hi, 32'h1234);
    chk("div_flush_lo", bus.lo, 32'h5678);

    // reset in the middle of a MUL
    bus.in_valid  = 1'b1;
    bus.funct     = 6'h18;
    bus.operand_1 = 32'd3;
    bus.operand_2 = 32'd4;
    step();
    chk("mul_busy_stall", {31'b0, bus.stall_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mul_reset_stall", {31'b0, bus.stall_req}, 32'd0);
    step();
    chk("mul_reset_hi", bus.hi, 32'd0);
    chk("mul_reset_lo", bus.lo, 32'd0);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("mul_reset_idle_stall", {31'b0, bus.stall_req}, 32'd0);
    for (int i = 0; i < 4; i++) step();
    chk("mul_reset_no_late_lo", bus.lo, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
